// File: rtl/jt12_timer_ctrl.sv
// jt12_timer_ctrl: timer register decode, busy flag and CSM key-on sequencer.
// Sits between the CPU bus port and the timer block.
module jt12_timer_ctrl #(
  parameter int BUSY_CYCLES = 32,
  parameter int BW          = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic       wr,
  input  logic       addr,
  input  logic [7:0] din,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode,
  output logic       csm_keyon,
  output logic       busy
);

  typedef enum logic {IDLE, KEYON} csm_t;

  csm_t          state;
  logic [7:0]    sel;
  logic [BW-1:0] cnt;
  logic [BW-1:0] cnt_next;
  logic          wr_addr;
  logic          wr_data;
  logic          wr_24;
  logic          wr_25;
  logic          wr_26;
  logic          wr_27;
  logic [1:0]    mode_next;
  logic          tick;

  assign wr_addr = wr && !addr;
  assign wr_data = wr && addr;
  assign wr_24   = wr_data && (sel == 8'h24);
  assign wr_25   = wr_data && (sel == 8'h25);
  assign wr_26   = wr_data && (sel == 8'h26);
  assign wr_27   = wr_data && (sel == 8'h27);
  assign tick    = cen && zero;

  // Mode written this cycle takes effect on the sequencer immediately
  assign mode_next = wr_27 ? din[7:6] : ch3_mode;

  always_comb begin
    cnt_next = cnt;
    if (wr_data)
      cnt_next = BW'(BUSY_CYCLES);
    else if (cen && cnt != '0)
      cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel          <= '0;
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      ch3_mode     <= 2'b00;
      cnt          <= '0;
      busy         <= 1'b0;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      cnt        <= cnt_next;
      busy       <= (cnt_next != '0);
      unique case (1'b1)
        wr_addr: sel <= din;
        wr_24:   value_A[9:2] <= din;
        wr_25:   value_A[1:0] <= din[1:0];
        wr_26:   value_B <= din;
        wr_27: begin
          ch3_mode     <= din[7:6];
          clr_flag_B   <= din[5];
          clr_flag_A   <= din[4];
          enable_irq_B <= din[3];
          enable_irq_A <= din[2];
          load_B       <= din[1];
          load_A       <= din[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      csm_keyon <= 1'b0;
    end else if (mode_next != 2'b10) begin
      state     <= IDLE;
      csm_keyon <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (tick && overflow_A) begin
          state     <= KEYON;
          csm_keyon <= 1'b1;
        end
        KEYON: if (tick && !overflow_A) begin
          state     <= IDLE;
          csm_keyon <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          csm_keyon <= 1'b0;
        end
      endcase
    end
  end

endmodule
